// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: camera-style test pattern source.
// Produces a PCLK (ACLK/2), HREF/VSYNC framing and an RGB565 byte stream of
// either incrementing bytes or eight vertical colour bars.
//
// Ports:
//   ACLK      in   system clock, all flops on its rising edge
//   ARESETN   in   asynchronous active-low reset
//   ENABLE    in   start / continue frame generation
//   RESOL     in   frame size select: 00 640x480, 01 1024x768, 10 1280x1024, 11 as 00
//   PATTERN   in   0 incrementing bytes, 1 colour bars
//   PCLK      out  pixel clock, ACLK/2, registered
//   HREF      out  high during active line bytes
//   VSYNC     out  high during the VSYNC lines
//   CAMDATA   out  RGB565 byte stream, high byte first
//   FRAME_END out  one-ACLK pulse when the last line of a frame ends
module cam_pattern_gen #(
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned VS_LINES = 3,
    parameter int unsigned V_BACK   = 17,
    parameter int unsigned V_FRONT  = 10,
    // Frame sizes selected by RESOL; widths must be multiples of 8.
    parameter int unsigned WIDTH0   = 640,
    parameter int unsigned HEIGHT0  = 480,
    parameter int unsigned WIDTH1   = 1024,
    parameter int unsigned HEIGHT1  = 768,
    parameter int unsigned WIDTH2   = 1280,
    parameter int unsigned HEIGHT2  = 1024
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       ENABLE,
    input  logic [1:0] RESOL,
    input  logic       PATTERN,
    output logic       PCLK,
    output logic       HREF,
    output logic       VSYNC,
    output logic [7:0] CAMDATA,
    output logic       FRAME_END
);

    typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

    state_e      state_q, state_d;
    logic        pclk_q;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic [1:0]  res_q, res_d;
    logic        pat_q, pat_d;
    logic [7:0]  bcnt_q, bcnt_d;
    logic        href_q, vsync_q, fend_q, fend_d;
    logic [7:0]  data_q;

    logic        tick;
    logic        start_frame;
    logic [15:0] width, height, line_last, v_last, pix;
    logic [2:0]  bar;
    logic [15:0] rgb;
    logic        href_n;
    logic [7:0]  data_n;

    // Everything advances on the edge where PCLK falls, so outputs are
    // stable across the following PCLK rising edge.
    assign tick = pclk_q;

    always_comb begin
        unique case (res_q)
            2'd1: begin
                width  = 16'(WIDTH1);
                height = 16'(HEIGHT1);
            end
            2'd2: begin
                width  = 16'(WIDTH2);
                height = 16'(HEIGHT2);
            end
            default: begin
                width  = 16'(WIDTH0);
                height = 16'(HEIGHT0);
            end
        endcase
        line_last = (width << 1) + 16'(H_BLANK) - 16'd1;
        case (state_q)
            StVsync:  v_last = 16'(VS_LINES - 1);
            StVback:  v_last = 16'(V_BACK - 1);
            StActive: v_last = height - 16'd1;
            StVfront: v_last = 16'(V_FRONT - 1);
            default:  v_last = 16'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        res_d       = res_q;
        pat_d       = pat_q;
        bcnt_d      = bcnt_q;
        fend_d      = 1'b0;
        start_frame = 1'b0;

        if (tick) begin
            if (state_q == StIdle) begin
                start_frame = ENABLE;
            end else if (hcnt_q == line_last) begin
                hcnt_d = 16'd0;
                if (vcnt_q == v_last) begin
                    vcnt_d = 16'd0;
                    case (state_q)
                        StVsync:  state_d = StVback;
                        StVback:  state_d = StActive;
                        StActive: state_d = StVfront;
                        StVfront: begin
                            fend_d = 1'b1;
                            if (ENABLE) start_frame = 1'b1;
                            else        state_d     = StIdle;
                        end
                        default:  state_d = StIdle;
                    endcase
                end else begin
                    vcnt_d = vcnt_q + 16'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 16'd1;
            end
        end

        // Frame parameters are captured only here, so mid-frame changes wait.
        if (start_frame) begin
            state_d = StVsync;
            hcnt_d  = 16'd0;
            vcnt_d  = 16'd0;
            res_d   = (RESOL == 2'b11) ? 2'b00 : RESOL;
            pat_d   = PATTERN;
            bcnt_d  = 8'd0;
        end

        // Output values for the PCLK period that begins at this tick.
        href_n = (state_d == StActive) && (hcnt_d < (width << 1));
        pix    = hcnt_d >> 1;
        unique case (res_q)
            2'd1:    bar = 3'(pix / 16'(WIDTH1 / 8));
            2'd2:    bar = 3'(pix / 16'(WIDTH2 / 8));
            default: bar = 3'(pix / 16'(WIDTH0 / 8));
        endcase
        unique case (bar)
            3'd0: rgb = 16'hFFFF;
            3'd1: rgb = 16'hFFE0;
            3'd2: rgb = 16'h07FF;
            3'd3: rgb = 16'h07E0;
            3'd4: rgb = 16'hF81F;
            3'd5: rgb = 16'hF800;
            3'd6: rgb = 16'h001F;
            default: rgb = 16'h0000;
        endcase
        if (!href_n)    data_n = 8'd0;
        else if (pat_q) data_n = hcnt_d[0] ? rgb[7:0] : rgb[15:8];
        else            data_n = bcnt_q;

        if (tick && href_n) bcnt_d = bcnt_q + 8'd1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pclk_q  <= 1'b0;
            state_q <= StIdle;
            hcnt_q  <= 16'd0;
            vcnt_q  <= 16'd0;
            res_q   <= 2'd0;
            pat_q   <= 1'b0;
            bcnt_q  <= 8'd0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            data_q  <= 8'd0;
            fend_q  <= 1'b0;
        end else begin
            pclk_q  <= ~pclk_q;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            res_q   <= res_d;
            pat_q   <= pat_d;
            bcnt_q  <= bcnt_d;
            fend_q  <= fend_d;
            if (tick) begin
                href_q  <= href_n;
                vsync_q <= (state_d == StVsync);
                data_q  <= data_n;
            end
        end
    end

    assign PCLK      = pclk_q;
    assign HREF      = href_q;
    assign VSYNC     = vsync_q;
    assign CAMDATA   = data_q;
    assign FRAME_END = fend_q;

endmodule

// File: doc/cam_pattern_gen.md
CAM_PATTERN_GEN -- requirements
Module: cam_pattern_gen

Interface
REQ-001 Parameter H_BLANK, 144: PCLK periods of HREF low after each active line.
REQ-002 Parameter VS_LINES, 3: line periods with VSYNC high at frame start.
REQ-003 Parameter V_BACK, 17: blank line periods after VSYNC, before the first active line.
REQ-004 Parameter V_FRONT, 10: blank line periods after the last active line.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low; ports are ACLK and ARESETN.
REQ-006 ACLK  in  1  system clock; all flops on its rising edge.
REQ-007 ARESETN  in  1  asynchronous active-low reset.
REQ-008 ENABLE  in  1  start or continue frame generation.
REQ-009 RESOL  in  2  frame size: 00 640x480, 01 1024x768, 10 1280x1024, 11 treated as 00.
REQ-010 PATTERN  in  1  0 incrementing bytes, 1 colour bars.
REQ-011 PCLK  out  1  camera pixel clock, ACLK/2, registered.
REQ-012 HREF  out  1  high during active line bytes.
REQ-013 VSYNC  out  1  high during the VS_LINES lines.
REQ-014 CAMDATA  out  8  RGB565 byte stream.
REQ-015 FRAME_END  out  1  one-ACLK pulse after the last line of a frame.

Function
REQ-016 PCLK SHALL toggle every ACLK cycle out of reset.
REQ-017 HREF, VSYNC and CAMDATA SHALL update only on the ACLK edge where PCLK goes 1->0, so they are stable at the PCLK rising edge.
REQ-018 Each line period SHALL be 2*W + H_BLANK PCLK periods, where W is the width for the latched RESOL.
REQ-019 Each frame SHALL be VS_LINES + V_BACK + H + V_FRONT line periods, where H is the height for the latched RESOL.
REQ-020 The state machine SHALL have states IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
REQ-021 IDLE->VSYNC SHALL occur on a PCLK-falling edge with ENABLE=1.
REQ-022 VFRONT SHALL go to VSYNC at the end of its last line if ENABLE=1, otherwise to IDLE.
REQ-023 RESOL and PATTERN SHALL be latched on entry to VSYNC; changes mid-frame have no effect until the next frame.
REQ-024 ENABLE deasserted mid-frame SHALL let the current frame complete; there is no truncation.
REQ-025 In ACTIVE, HREF SHALL be 1 for the first 2*W PCLK periods of each line and 0 for the next H_BLANK; HREF SHALL be 0 in all other states.
REQ-026 Each pixel SHALL be 2 bytes, RGB565, high byte {R[4:0],G[5:3]} first, then {G[2:0],B[4:0]}.
REQ-027 PATTERN=0: CAMDATA SHALL be an 8-bit counter cleared at VSYNC entry, incremented per HREF byte, wrapping 255->0, and continuing across lines.
REQ-028 PATTERN=1: the line SHALL be split into 8 bars of W/8 pixels: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
REQ-029 CAMDATA SHALL be 0 whenever HREF=0.
REQ-030 FRAME_END SHALL be 1 for exactly one ACLK cycle on the edge that ends the last VFRONT line.

Reset
REQ-031 ARESETN=0 SHALL immediately force PCLK=0, HREF=0, VSYNC=0, CAMDATA=0, FRAME_END=0, state IDLE, and clear all counters, including mid-frame.
REQ-032 After ARESETN is released, the first PCLK rising edge SHALL occur on the first ACLK edge, and the frame SHALL start per REQ-021.

Verification
REQ-033 Reset then ENABLE=1, RESOL=00, PATTERN=0 -> VSYNC high 3*1424 PCLKs, then 480 HREF pulses of 1280 PCLKs spaced 1424, with the first byte 00 and byte 256 of the frame 00 (wrap).
REQ-034 RESOL=00, PATTERN=1 -> each line is bytes FF,FF repeated 80 pixels, then FF,E0 x80, ..., ending 00,00 x80; HREF low bytes are 00.
REQ-035 RESOL=10 -> 1024 HREF pulses of 2560 PCLKs per frame, with a frame of 1054 lines and FRAME_END pulsed once per 1054*2704 PCLKs.
REQ-036 Change RESOL 00->01 mid-frame -> the current frame stays 640x480 and the next frame is 1024x768.
REQ-037 ENABLE low at line 100 of ACTIVE -> the frame completes, FRAME_END pulses, the block enters IDLE, and there are no further VSYNC pulses while ENABLE=0.
REQ-038 ARESETN low during ACTIVE -> all outputs 0 within the same cycle; after release with ENABLE=1, a new frame starts with VSYNC and the counter at 00.
